gated_delay_line: RTL
=====================

// Module: gated_delay_line
// PURPOSE
//   Parametrised enable-gated storage element: DEPTH stages of WIDTH-bit registers.
//   Each stage holds a valid flag and shifts only while ena is high.
//   Generalises the single-bit enable-gated D storage element to multi-bit, multi-stage operation.
//   Adds per-entry valid tracking, flush and occupancy count.
//   Used as a programmable-latency sample delay in front of datapath consumers.
// PARAMETERS
//   WIDTH  8  data bits per stage (>=1)
//   DEPTH  4  number of stages = latency in enabled cycles (>=1)
// PORTS
//   clk       in   1                  rising-edge clock
//   reset     in   1                  synchronous, active-high reset
//   d         in   WIDTH              data sampled into stage 0
//   d_valid   in   1                  valid flag sampled with d
//   ena       in   1                  advance enable: shift when 1, hold when 0
//   flush     in   1                  synchronous clear of all stages (not a reset)
//   q         out  WIDTH              data of stage DEPTH-1 (registered)
//   q_valid   out  1                  valid flag of stage DEPTH-1
//   fill      out  $clog2(DEPTH+1)    number of stages holding valid entries
// BEHAVIOUR
//   - One clock; reset is synchronous and active-high; all state updates on rising clk.
//   - Priority per edge: reset > flush > ena > hold.
//   - reset=1: all stage data=0, all valid=0, fill=0. Hence q=0, q_valid=0 next cycle.
//     Applies mid-shift; in-flight entries are discarded.
//   - flush=1 (reset=0): same clearing as reset.
//     ena and d are ignored on that edge; flush+ena does not load d.
//   - ena=1: stage0 <= {d_valid,d}; stage[i] <= stage[i-1] for i=1..DEPTH-1.
//     The old stage DEPTH-1 entry is dropped.
//   - ena=0: every stage, q, q_valid and fill hold their values. d and d_valid are ignored.
//   - q/q_valid are driven directly from stage DEPTH-1 (no comb path from d).
//     Latency is exactly DEPTH enabled edges; disabled cycles add no latency.
//   - Invalid entries still carry and shift data. q shows that data with q_valid=0.
//   - fill on ena edge: fill + d_valid - valid[DEPTH-1].
//     Never exceeds DEPTH and never underflows; invariant fill == popcount(valid[]).
//     Simultaneous insert and drop leaves fill unchanged.
//   - DEPTH=1: single register; q is d after one enabled edge; fill is 0 or 1.
//   - No backpressure: data shifted out of stage DEPTH-1 is lost. Callers size DEPTH accordingly.
//   - X on d with d_valid=0 must not propagate into valid or fill.
// TESTING
//   1 Reset: hold reset=1 for 2 cycles with ena=1, d=8'hFF, d_valid=1 -> q=0, q_valid=0, fill=0.
//   2 Latency: DEPTH=4, ena=1, feed d=1,2,3,4,5 valid.
//     -> q=1 with q_valid=1 on 4th edge after first load; fill goes 1,2,3,4,4.
//   3 Hold: after loading 8'hA5 into stage0, drop ena for 5 cycles.
//     -> q/fill unchanged; A5 emerges after 3 further enabled edges.
//   4 Bubbles: ena=1, d_valid pattern 1,0,1,0 with d=10..13.
//     -> q_valid pattern 1,0,1,0 at cycles 4..7; fill peaks at 2.
//   5 Flush vs ena: pipeline full (fill=4), assert flush=1 and ena=1 with d=8'h55.
//     -> next cycle fill=0, q_valid=0, q=0; 8'h55 is not loaded.
//   6 Reset mid-operation: fill=3, assert reset 1 cycle.
//     -> all cleared; subsequent load of 8'h0C appears at q after exactly 4 enabled edges.

Source files
------------

// File: rtl/gated_delay_line.sv
// Enable-gated multi-stage delay line.
// DEPTH stages of WIDTH-bit data, each with a valid flag. The line advances only
// on edges where ena is high. Reset and flush clear every stage, and an occupancy
// count tracks how many stages hold valid entries.
module gated_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [WIDTH-1:0]             d,
  input  logic                         d_valid,
  input  logic                         ena,
  input  logic                         flush,
  output logic [WIDTH-1:0]             q,
  output logic                         q_valid,
  output logic [$clog2(DEPTH+1)-1:0]   fill
);

  localparam int FW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] data_p [DEPTH];
  logic [DEPTH-1:0] vld_p;
  logic [FW-1:0]    fill_r;

  // The count moves by at most one per edge: it goes up on an insert, down on a drop,
  // and stays the same when both happen. Because it is driven only by valid flags,
  // unknown data carried with d_valid=0 cannot disturb the count.
  function automatic logic [FW-1:0] fill_step(input logic [FW-1:0] f,
                                              input logic          ins,
                                              input logic          drop);
    logic [FW-1:0] r;
    r = f;
    if (ins && !drop)
      r = f + FW'(1);
    else if (!ins && drop)
      r = f - FW'(1);
    return r;
  endfunction

  // Stage registers. Priority is reset > flush > ena > hold. Data is cleared too,
  // so q reads zero after a clear.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int i = 0; i < DEPTH; i++)
        data_p[i] <= '0;
      vld_p  <= '0;
      fill_r <= '0;
    end else if (ena) begin
      // stage 0 takes the input; each later stage takes its predecessor; the last entry falls off
      data_p[0] <= d;
      vld_p[0]  <= d_valid;
      for (int i = 1; i < DEPTH; i++) begin
        data_p[i] <= data_p[i-1];
        vld_p[i]  <= vld_p[i-1];
      end
      fill_r <= fill_step(fill_r, d_valid, vld_p[DEPTH-1]);
    end
  end

  // The outputs come straight from the last stage, so there is no path from d to q.
  always_comb begin
    q       = data_p[DEPTH-1];
    q_valid = vld_p[DEPTH-1];
    fill    = fill_r;
  end

endmodule
